// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-to-decode queue.
// fetch_entry_t is one buffered {pc, instr} pair.
package fetch_pkg;

    localparam int WORD_W = 32;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    localparam logic [WORD_W-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem: entry storage for fetch_queue.
// One write port and an asynchronous read port; the array has no reset.
module fetch_queue_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer between fetch and decode, flushed on branch_taken.
// Define FETCH_QUEUE_BYPASS_EN for zero-latency pass-through when empty.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WORD_W-1:0]        in_pc,
    input  logic [WORD_W-1:0]        in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WORD_W-1:0]        out_pc,
    output logic [WORD_W-1:0]        out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    import fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]       rd_ptr;
    logic [PW-1:0]       wr_ptr;
    logic                empty;
    logic                full;
    logic                byp;
    logic                pass;
    logic                push;
    logic                pop;
    logic                we;
    logic [2*WORD_W-1:0] rdata;

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) &&
                   (rd_ptr[AW] != wr_ptr[AW]);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Reset low acts like flush, so it also blocks pass-through.
    assign byp = empty & in_valid & ~flush & rst;
`else
    assign byp = 1'b0;
`endif

    assign in_ready  = ~full;
    assign out_valid = (~empty | byp) & ~flush;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign pass      = byp & out_ready;
    assign we        = push & ~pass;
    assign count     = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (we) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop && !pass) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    fetch_queue_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (2*WORD_W),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_comb begin
        out_pc    = '0;
        out_instr = WORD_W'(NOP_INSTR);
        if (out_valid) begin
            if (byp) begin
                out_pc    = in_pc;
                out_instr = in_instr;
            end else begin
                out_pc    = rdata[2*WORD_W-1:WORD_W];
                out_instr = rdata[WORD_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors against a FIFO reference queue.
// Honours FETCH_QUEUE_BYPASS_EN when the design is built with it.
module tb_fetch_queue;

    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    bit acc;
    fetch_entry_t q[$];

    fetch_queue #(
        .DEPTH  (DEPTH),
        .WORD_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Check one cycle against the reference queue, then advance it.
    task automatic cyc();
        bit byp;
        bit ev;
        bit pop;
        fetch_entry_t h;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (q.size() == 0) && in_valid && !flush && rst;
`endif
        ev = (q.size() != 0 || byp) && !flush;
        h  = '0;
        if (ev) begin
            if (byp) h = '{pc: in_pc, instr: in_instr};
            else     h = q[0];
        end
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_pc", out_pc, h.pc);
        chk("out_instr", out_instr, h.instr);
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("count", 32'(count), 32'(q.size()));
        acc = in_valid && (q.size() < DEPTH) && !flush && rst;
        pop = ev && out_ready;
        if (!rst || flush) begin
            q.delete();
        end else if (!(byp && out_ready)) begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back('{pc: in_pc, instr: in_instr});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int pushed;
        int n;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'd44;
        in_instr  = 32'd55;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;

        // fill to capacity, then offer one more
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'(4 * (i + 1));
            in_instr = 32'hA000 + 32'(i);
            cyc();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        in_pc    = 32'd20;
        in_instr = 32'hA004;
        cyc();
        chk("fill_no_fifth", 32'(count), 32'd4);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) cyc();

        // streaming
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'(4 * (k + 1));
            in_instr = 32'hB000 + 32'(k);
            cyc();
        end
        in_valid = 1'b0;
        repeat (2) cyc();

        // flush with three entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'd40 + 32'(4 * i);
            in_instr = 32'hD000 + 32'(i);
            cyc();
        end
        flush    = 1'b1;
        in_pc    = 32'd100;
        in_instr = 32'hD100;
        cyc();
        flush = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        in_pc    = 32'd200;
        in_instr = 32'hD200;
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("flush_next_pc", out_pc, 32'd200);
        repeat (2) cyc();

        // wrap with random out_ready
        pushed = 0;
        n      = 0;
        while ((pushed < 10 || q.size() != 0) && n < 200) begin
            in_valid  = (pushed < 10);
            in_pc     = 32'd300 + 32'(4 * pushed);
            in_instr  = 32'hC000 + 32'(pushed);
            out_ready = 1'($urandom_range(0, 1));
            cyc();
            if (acc) pushed++;
            n++;
        end
        chk("wrap_done", 32'(pushed == 10 && q.size() == 0), 32'd1);
        in_valid = 1'b0;

        // reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'd600 + 32'(4 * i);
            in_instr = 32'hE000 + 32'(i);
            cyc();
        end
        rst = 1'b0;
        cyc();
        rst      = 1'b1;
        in_valid = 1'b0;
        cyc();
        chk("midrst_count", 32'(count), 32'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_pc     = 32'd500;
        in_instr  = 32'h1234;
        #1;
        chk("byp_instr", out_instr, 32'h1234);
        chk("byp_valid", 32'(out_valid), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("byp_count", 32'(count), 32'd0);
        cyc();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
